// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - stack command encoding shared with the control-unit decoder
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_DROP    = 3'd2,
    OP_REPLACE = 3'd3,
    OP_SWAP    = 3'd4,
    OP_DUP     = 3'd5,
    OP_CLEAR   = 3'd6,
    OP_RSVD    = 3'd7
  } stack_op_t;

endpackage

// File: rtl/data_stack_if.sv
// rtl/data_stack_if.sv - command/status bundle between control unit and data stack
interface data_stack_if #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 64
);
  import stack_pkg::*;
  localparam int AW = $clog2(DEPTH);

  stack_op_t        op;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [AW:0]      depth;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  modport master (output op, D, input top, next, depth, empty, full, ovf, unf);
  modport slave  (input op, D, output top, next, depth, empty, full, ovf, unf);
endinterface

// File: rtl/stack_ptr.sv
// rtl/stack_ptr.sv - saturating depth counter with pre-decremented read indices
module stack_ptr #(
  parameter int  DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [AW:0]   depth,
  output logic          empty,
  output logic          full,
  output logic [AW-1:0] depth_m1,
  output logic [AW-1:0] depth_m2
);
  logic [AW:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign depth    = cnt;
  assign empty    = (cnt == '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  // Indices wrap harmlessly when shallow; readers mask by depth.
  assign depth_m1 = AW'(cnt - (AW+1)'(1));
  assign depth_m2 = AW'(cnt - (AW+1)'(2));
endmodule

// File: rtl/data_stack.sv
// rtl/data_stack.sv - single-clock LIFO with op-coded port, masked top/next and sticky error flags
module data_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 64
) (
  input logic         clk,
  input logic         rst,
  data_stack_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      depth;
  logic             empty, full, two_plus;
  logic [AW-1:0]    m1, m2;
  logic             inc, dec, clr;
  logic             wr_push, wr_dup, wr_repl, wr_swap;
  logic             ovf_set, unf_set, ovf_q, unf_q;

  assign two_plus = (depth >= (AW+1)'(2));

  always_comb begin
    inc = 1'b0; dec = 1'b0; clr = 1'b0;
    wr_push = 1'b0; wr_dup = 1'b0; wr_repl = 1'b0; wr_swap = 1'b0;
    ovf_set = 1'b0; unf_set = 1'b0;
    case (bus.op)
      OP_PUSH:    if (full) ovf_set = 1'b1; else begin inc = 1'b1; wr_push = 1'b1; end
      OP_DROP:    if (empty) unf_set = 1'b1; else dec = 1'b1;
      OP_REPLACE: if (empty) unf_set = 1'b1; else wr_repl = 1'b1;
      OP_SWAP:    if (!two_plus) unf_set = 1'b1; else wr_swap = 1'b1;
      // Empty is checked first so an empty DUP never reports overflow.
      OP_DUP: begin
        if (empty)     unf_set = 1'b1;
        else if (full) ovf_set = 1'b1;
        else begin inc = 1'b1; wr_dup = 1'b1; end
      end
      OP_CLEAR:   clr = 1'b1;
      default:    ;
    endcase
  end

  stack_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (inc),
    .dec      (dec),
    .clr      (clr),
    .depth    (depth),
    .empty    (empty),
    .full     (full),
    .depth_m1 (m1),
    .depth_m2 (m2)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_push) mem[depth[AW-1:0]] <= bus.D;
      if (wr_dup)  mem[depth[AW-1:0]] <= mem[m1];
      if (wr_repl) mem[m1] <= bus.D;
      if (wr_swap) begin
        mem[m1] <= mem[m2];
        mem[m2] <= mem[m1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  assign bus.top   = empty    ? '0 : mem[m1];
  assign bus.next  = two_plus ? mem[m2] : '0;
  assign bus.depth = depth;
  assign bus.empty = empty;
  assign bus.full  = full;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule

// File: tb/tb_data_stack.sv
// tb/tb_data_stack.sv - directed and random checks of data_stack against an array model
module tb_data_stack;
  import stack_pkg::*;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   errs = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  data_stack_if #(.WIDTH(8),  .DEPTH(4))  bus0 ();
  data_stack_if #(.WIDTH(36), .DEPTH(64)) bus1 ();

  data_stack #(.WIDTH(8),  .DEPTH(4))  dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  data_stack #(.WIDTH(36), .DEPTH(64)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  // model: entries bottom-up in mm[k][0..md[k]-1]
  logic [35:0] mm [2][64];
  int          md [2];
  bit          movf [2];
  bit          munf [2];

  function automatic void chk(string name, logic [35:0] act, logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void mstep(int k, logic [2:0] op, logic [35:0] d, logic r);
    int cap = (k == 0) ? 4 : 64;
    logic [35:0] mask = (k == 0) ? 36'hFF : {36{1'b1}};
    logic [35:0] t;
    int n = md[k];
    if (r) begin
      md[k] = 0; movf[k] = 0; munf[k] = 0;
      return;
    end
    case (op)
      3'd1: if (n == cap) movf[k] = 1; else begin mm[k][n] = d & mask; md[k] = n + 1; end
      3'd2: if (n == 0) munf[k] = 1; else md[k] = n - 1;
      3'd3: if (n == 0) munf[k] = 1; else mm[k][n-1] = d & mask;
      3'd4: if (n < 2) munf[k] = 1;
            else begin t = mm[k][n-1]; mm[k][n-1] = mm[k][n-2]; mm[k][n-2] = t; end
      3'd5: if (n == 0) munf[k] = 1;
            else if (n == cap) movf[k] = 1;
            else begin mm[k][n] = mm[k][n-1]; md[k] = n + 1; end
      3'd6: begin md[k] = 0; movf[k] = 0; munf[k] = 0; end
      default: ;
    endcase
  endfunction

  function automatic logic [35:0] etop(int k);
    return (md[k] >= 1) ? mm[k][md[k]-1] : 36'h0;
  endfunction

  function automatic logic [35:0] enext(int k);
    return (md[k] >= 2) ? mm[k][md[k]-2] : 36'h0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s0.top",   {28'h0, bus0.top},  etop(0));
      chk("s0.next",  {28'h0, bus0.next}, enext(0));
      chk("s0.depth", 36'(bus0.depth),    36'(md[0]));
      chk("s0.empty", 36'(bus0.empty),    36'(md[0] == 0));
      chk("s0.full",  36'(bus0.full),     36'(md[0] == 4));
      chk("s0.ovf",   36'(bus0.ovf),      36'(movf[0]));
      chk("s0.unf",   36'(bus0.unf),      36'(munf[0]));
      chk("s1.top",   bus1.top,           etop(1));
      chk("s1.next",  bus1.next,          enext(1));
      chk("s1.depth", 36'(bus1.depth),    36'(md[1]));
      chk("s1.empty", 36'(bus1.empty),    36'(md[1] == 0));
      chk("s1.full",  36'(bus1.full),     36'(md[1] == 64));
      chk("s1.flags", 36'({bus1.ovf, bus1.unf}), 36'({movf[1], munf[1]}));
    end
  end

  task automatic cyc(logic [2:0] o0, logic [7:0] d0, logic r0,
                     logic [2:0] o1, logic [35:0] d1, logic r1);
    @(negedge clk);
    #1;
    bus0.op = stack_op_t'(o0); bus0.D = d0; rst0 = r0;
    bus1.op = stack_op_t'(o1); bus1.D = d1; rst1 = r1;
    @(posedge clk);
    #1;
    mstep(0, o0, {28'h0, d0}, r0);
    mstep(1, o1, d1, r1);
  endtask

  task automatic op0(logic [2:0] o, logic [7:0] d);
    cyc(o, d, 1'b0, 3'd0, 36'h0, 1'b0);
  endtask

  task automatic lit(string name, logic [35:0] act, logic [35:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    bus0.op = OP_NOP; bus0.D = '0; bus1.op = OP_NOP; bus1.D = '0;
    rst0 = 1'b1; rst1 = 1'b1;
    md[0] = 0; md[1] = 0; movf = '{0, 0}; munf = '{0, 0};
    cyc(3'd0, 8'h0, 1'b1, 3'd0, 36'h0, 1'b1);
    cyc(3'd0, 8'h0, 1'b1, 3'd0, 36'h0, 1'b1);
    chk_en = 1'b1;
    lit("rst.depth", 36'(bus0.depth), 36'h0);
    lit("rst.empty", 36'(bus0.empty), 36'h1);
    lit("rst.top",   36'(bus0.top),   36'h0);

    op0(3'd1, 8'h11); op0(3'd1, 8'h22); op0(3'd1, 8'h33);
    lit("p3.top",   36'(bus0.top),   36'h33);
    lit("p3.next",  36'(bus0.next),  36'h22);
    lit("p3.depth", 36'(bus0.depth), 36'h3);
    lit("p3.full",  36'(bus0.full),  36'h0);
    op0(3'd1, 8'h44); op0(3'd1, 8'h55);
    lit("ovf.full", 36'(bus0.full), 36'h1);
    lit("ovf.ovf",  36'(bus0.ovf),  36'h1);
    lit("ovf.top",  36'(bus0.top),  36'h44);
    op0(3'd2, 8'h0);
    lit("drop.top", 36'(bus0.top), 36'h33);
    lit("drop.ovf", 36'(bus0.ovf), 36'h1);

    op0(3'd6, 8'h0); op0(3'd1, 8'h11); op0(3'd1, 8'h22);
    op0(3'd4, 8'h0);
    lit("swap.top",  36'(bus0.top),  36'h11);
    lit("swap.next", 36'(bus0.next), 36'h22);
    op0(3'd5, 8'h0);
    lit("dup.depth", 36'(bus0.depth), 36'h3);
    lit("dup.next",  36'(bus0.next),  36'h11);
    op0(3'd3, 8'h99);
    lit("repl.top", 36'(bus0.top), 36'h99);
    op0(3'd7, 8'hAB);
    lit("rsvd.top", 36'(bus0.top), 36'h99);

    op0(3'd6, 8'h0); op0(3'd2, 8'h0);
    lit("unf.unf",  36'(bus0.unf),  36'h1);
    lit("unf.next", 36'(bus0.next), 36'h0);
    op0(3'd1, 8'h07); op0(3'd4, 8'h0);
    lit("swap1.top",   36'(bus0.top),   36'h07);
    lit("swap1.depth", 36'(bus0.depth), 36'h1);
    op0(3'd6, 8'h0);
    lit("clr.unf",   36'(bus0.unf),   36'h0);
    lit("clr.depth", 36'(bus0.depth), 36'h0);

    op0(3'd1, 8'h01); op0(3'd1, 8'h02);
    cyc(3'd1, 8'h03, 1'b1, 3'd0, 36'h0, 1'b0);
    lit("rstp.depth", 36'(bus0.depth), 36'h0);
    lit("rstp.top",   36'(bus0.top),   36'h0);
    op0(3'd1, 8'h05);
    lit("rstp.after", 36'({bus0.top, bus0.next}), 36'h0500);

    for (int i = 0; i < 6000; i++) begin
      cyc(3'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 299) == 0),
          3'(($urandom_range(0, 9) < 3) ? 1 : $urandom_range(0, 7)),
          {4'($urandom), 32'($urandom)}, ($urandom_range(0, 1999) == 0));
    end
    for (int i = 0; i < 70; i++) cyc(3'd1, 8'($urandom), 1'b0, 3'd1, 36'(i), 1'b0);
    cyc(3'd5, 8'h0, 1'b0, 3'd5, 36'h0, 1'b0);
    lit("full.ovf", 36'({bus0.ovf, bus1.ovf, bus1.full}), 36'h7);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
